// File: rtl/m_div_iter_pkg.sv
// ---------------------------------------------------------------------------
// m_div_iter_pkg
//   Shared definitions for the iterative RV64 M-extension divider:
//   datapath width, ALU opcode encodings, divide constants, FSM state
//   encoding and the divide-op decoder.
// ---------------------------------------------------------------------------
package m_div_iter_pkg;

    localparam int GLOBAL_XLEN = 64;

    // Divide constants (full width and 32-bit W width)
    localparam logic [63:0] NEGATIVE_1         = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] NEGATIVE_1_W       = 32'hFFFF_FFFF;
    localparam logic [63:0] DIV_MOST_NEG_INT   = 64'h8000_0000_0000_0000;
    localparam logic [31:0] DIV_MOST_NEG_INT_W = 32'h8000_0000;

    // ALU operation encodings (subset relevant to the M extension)
    localparam logic [5:0] ALU_OP_ADD   = 6'h00;
    localparam logic [5:0] ALU_OP_MUL   = 6'h10;
    localparam logic [5:0] ALU_OP_DIV   = 6'h18;
    localparam logic [5:0] ALU_OP_DIVU  = 6'h19;
    localparam logic [5:0] ALU_OP_REM   = 6'h1A;
    localparam logic [5:0] ALU_OP_REMU  = 6'h1B;
    localparam logic [5:0] ALU_OP_DIVW  = 6'h1C;
    localparam logic [5:0] ALU_OP_DIVUW = 6'h1D;
    localparam logic [5:0] ALU_OP_REMW  = 6'h1E;
    localparam logic [5:0] ALU_OP_REMUW = 6'h1F;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE   = 2'd0,
        DIV_STATE_DIVIDE = 2'd1,
        DIV_STATE_FIXUP  = 2'd2,
        DIV_STATE_DONE   = 2'd3
    } div_state_e;

    typedef struct packed {
        logic is_div;     // one of the eight DIV*/REM* codes
        logic is_signed;  // DIV/REM/DIVW/REMW
        logic is_rem;     // remainder wanted instead of quotient
        logic is_w;       // 32-bit W variant
    } div_op_t;

    function automatic div_op_t decode_div_op(input logic [5:0] op);
        div_op_t d;
        d = '0;
        case (op)
            ALU_OP_DIV:   begin d.is_div = 1'b1; d.is_signed = 1'b1; end
            ALU_OP_DIVU:  begin d.is_div = 1'b1; end
            ALU_OP_REM:   begin d.is_div = 1'b1; d.is_signed = 1'b1; d.is_rem = 1'b1; end
            ALU_OP_REMU:  begin d.is_div = 1'b1; d.is_rem = 1'b1; end
            ALU_OP_DIVW:  begin d.is_div = 1'b1; d.is_signed = 1'b1; d.is_w = 1'b1; end
            ALU_OP_DIVUW: begin d.is_div = 1'b1; d.is_w = 1'b1; end
            ALU_OP_REMW:  begin d.is_div = 1'b1; d.is_signed = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; end
            ALU_OP_REMUW: begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; end
            default:      d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/m_div_iter.sv
// ---------------------------------------------------------------------------
// m_div_iter
//   Iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and their
//   W variants. Divides unsigned magnitudes one quotient bit per cycle, then
//   applies sign fixup and W sign-extension. Divide-by-zero and signed
//   overflow bypass the iteration and complete in one cycle.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           synchronous active-low reset
//   start_i          request valid this cycle
//   kill_i           flush: abandon in-flight op, suppress its result
//   alu_operation_i  ALU opcode (only DIV*/REM* codes are accepted)
//   a_i, b_i         dividend (rs1), divisor (rs2)
//   result_o         registered result, held until the next completion
//   valid_o          one-cycle completion pulse
//   stall_o          hold upstream pipeline (combinational)
// ---------------------------------------------------------------------------
module m_div_iter
    import m_div_iter_pkg::*;
#(
    parameter int XLEN = GLOBAL_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [5:0]      alu_operation_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            stall_o
);

    localparam int CNT_W = $clog2(XLEN + 1);

    div_state_e        state_q;
    logic              is_rem_q, is_w_q;
    logic              neg_quot_q, neg_rem_q;
    logic [XLEN-1:0]   divisor_q, rem_q, quot_q;
    logic [CNT_W-1:0]  cnt_q;

    // W results are always the low word sign-extended, even for unsigned ops.
    function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] x, input logic w);
        return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    // ------------------------------------------------------------------
    // Issue-side operand preparation
    // ------------------------------------------------------------------
    div_op_t         op_in;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, quot_init, special_res;
    logic            a_neg, b_neg, div_zero, overflow, accept;

    assign op_in = decode_div_op(alu_operation_i);

    always_comb begin
        a_ext = a_i;
        b_ext = b_i;
        if (op_in.is_w) begin
            a_ext = {{(XLEN-32){op_in.is_signed & a_i[31]}}, a_i[31:0]};
            b_ext = {{(XLEN-32){op_in.is_signed & b_i[31]}}, b_i[31:0]};
        end
        a_neg = op_in.is_signed & a_ext[XLEN-1];
        b_neg = op_in.is_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        // W magnitudes fit in 32 bits; park them in the top half so the
        // dividend MSB is shifted into the remainder first.
        quot_init = op_in.is_w ? (a_mag << 32) : a_mag;

        div_zero = (b_ext == '0);
        if (op_in.is_w)
            overflow = op_in.is_signed && (a_ext[31:0] == DIV_MOST_NEG_INT_W)
                                       && (b_ext[31:0] == NEGATIVE_1_W);
        else
            overflow = op_in.is_signed && (a_ext == DIV_MOST_NEG_INT)
                                       && (b_ext == NEGATIVE_1);

        if (div_zero)
            special_res = op_in.is_rem ? a_ext : NEGATIVE_1;
        else if (op_in.is_w)
            special_res = op_in.is_rem ? '0 : {{(XLEN-32){1'b1}}, DIV_MOST_NEG_INT_W};
        else
            special_res = op_in.is_rem ? '0 : DIV_MOST_NEG_INT;
        special_res = fmt_w(special_res, op_in.is_w);
    end

    assign accept  = (state_q == DIV_STATE_IDLE) & start_i & op_in.is_div & ~kill_i;
    assign stall_o = accept | (state_q == DIV_STATE_DIVIDE) | (state_q == DIV_STATE_FIXUP);

    // ------------------------------------------------------------------
    // Restoring step: shift {rem,quot} left, trial-subtract the divisor
    // ------------------------------------------------------------------
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_step, quot_step;

    always_comb begin
        trial = {rem_q, quot_q[XLEN-1]} - {1'b0, divisor_q};
        if (!trial[XLEN]) begin
            rem_step  = trial[XLEN-1:0];
            quot_step = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
            quot_step = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Sign fixup and result selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

    always_comb begin
        quot_fix = neg_quot_q ? -quot_q : quot_q;
        rem_fix  = neg_rem_q  ? -rem_q  : rem_q;
        fix_res  = fmt_w(is_rem_q ? rem_fix : quot_fix, is_w_q);
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= DIV_STATE_IDLE;
            is_rem_q   <= 1'b0;
            is_w_q     <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            result_o   <= '0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (kill_i) begin
                // Flush: drop the op, keep the last delivered result.
                state_q <= DIV_STATE_IDLE;
            end else begin
                case (state_q)
                    DIV_STATE_IDLE: begin
                        if (accept) begin
                            is_rem_q   <= op_in.is_rem;
                            is_w_q     <= op_in.is_w;
                            neg_quot_q <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            divisor_q  <= b_mag;
                            rem_q      <= '0;
                            quot_q     <= quot_init;
                            if (div_zero || overflow) begin
                                result_o <= special_res;
                                valid_o  <= 1'b1;
                                state_q  <= DIV_STATE_DONE;
                            end else begin
                                cnt_q   <= op_in.is_w ? CNT_W'(32) : CNT_W'(XLEN);
                                state_q <= DIV_STATE_DIVIDE;
                            end
                        end
                    end
                    DIV_STATE_DIVIDE: begin
                        rem_q  <= rem_step;
                        quot_q <= quot_step;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1))
                            state_q <= DIV_STATE_FIXUP;
                    end
                    DIV_STATE_FIXUP: begin
                        result_o <= fix_res;
                        valid_o  <= 1'b1;
                        state_q  <= DIV_STATE_DONE;
                    end
                    DIV_STATE_DONE: begin
                        state_q <= DIV_STATE_IDLE;
                    end
                    default: state_q <= DIV_STATE_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m_div_iter.sv
module tb_m_div_iter;
    import m_div_iter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [5:0]  alu_operation_i = ALU_OP_ADD;
    logic [63:0] a_i = '0;
    logic [63:0] b_i = '0;
    logic [63:0] result_o;
    logic        valid_o;
    logic        stall_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] last_res = '0;

    m_div_iter #(.XLEN(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i),
        .alu_operation_i(alu_operation_i), .a_i(a_i), .b_i(b_i),
        .result_o(result_o), .valid_o(valid_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V divide semantics with plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        logic [31:0]     r32;
        logic [63:0]     r;
        sa = a; sb = b; ua = a; ub = b;
        sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        r = '0; r32 = '0;
        case (op)
            ALU_OP_DIV:  if (sb == 0) r = '1; else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) r = a; else r = sa / sb;
            ALU_OP_REM:  if (sb == 0) r = a;  else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) r = 0; else r = sa % sb;
            ALU_OP_DIVU: if (ub == 0) r = '1; else r = ua / ub;
            ALU_OP_REMU: if (ub == 0) r = a;  else r = ua % ub;
            default: begin
                case (op)
                    ALU_OP_DIVW:  if (sb32 == 0) r32 = '1; else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = a[31:0]; else r32 = sa32 / sb32;
                    ALU_OP_REMW:  if (sb32 == 0) r32 = a[31:0]; else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = 0; else r32 = sa32 % sb32;
                    ALU_OP_DIVUW: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
                    default:      if (ub32 == 0) r32 = a[31:0]; else r32 = ua32 % ub32;
                endcase
                r = {{32{r32[31]}}, r32};
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, sgn;
        w   = (op == ALU_OP_DIVW) || (op == ALU_OP_DIVUW) || (op == ALU_OP_REMW) || (op == ALU_OP_REMUW);
        sgn = (op == ALU_OP_DIV) || (op == ALU_OP_REM) || (op == ALU_OP_DIVW) || (op == ALU_OP_REMW);
        if (w) begin
            if (b[31:0] == 0) return 1;
            if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        if (b == 0) return 1;
        if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 66;
    endfunction

    // Issue one op at the current cycle (called just after a rising edge),
    // wait for valid_o, and check latency, result and the stall profile.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        logic s0, v0, got;
        int   vcyc, stall_bad;
        logic [63:0] res;
        alu_operation_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk_i);
        s0 = stall_o; v0 = valid_o;
        @(posedge clk_i); #1;
        start_i = 1'b0; a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
        got = 1'b0; vcyc = 0; stall_bad = 0; res = '0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk_i);
            if (valid_o) begin
                got = 1'b1; vcyc = c; res = result_o;
                if (stall_o) stall_bad++;
            end else if (!stall_o) begin
                stall_bad++;
            end
            @(posedge clk_i); #1;
        end
        chk({tag, ".stall_c0"}, {63'd0, s0}, 64'd1);
        chk({tag, ".no_valid_c0"}, {63'd0, v0}, 64'd0);
        chk({tag, ".latency"}, 64'(vcyc), 64'(lat));
        chk({tag, ".result"}, res, exp);
        chk({tag, ".stall_profile"}, 64'(stall_bad), 64'd0);
        last_res = exp;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [63:0] a, b;
        int          spurious;
        ops = '{ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
                ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW};

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset.valid", {63'd0, valid_o}, 64'd0);
        chk("reset.result", result_o, 64'd0);
        chk("reset.stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Directed cases
        run_op("div_neg7_2", ALU_OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem_neg7_2", ALU_OP_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divu_by0", ALU_OP_DIVU, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_by0", ALU_OP_REMU, 64'd100, 64'd0, 64'd100, 1);
        run_op("div_ovf", ALU_OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", ALU_OP_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("divuw", ALU_OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("remw", ALU_OP_REMW, 64'h1_0000_0007, -64'sd2, 64'd1, 34);

        // Non-divide op is ignored
        alu_operation_i = ALU_OP_MUL; a_i = 64'd6; b_i = 64'd7; start_i = 1'b1;
        @(negedge clk_i);
        chk("mul.stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        spurious = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (valid_o) spurious++;
        end
        chk("mul.no_valid", 64'(spurious), 64'd0);
        chk("mul.result_held", result_o, last_res);
        @(posedge clk_i); #1;

        // Kill at cycle 10 of a DIV, new DIVU at cycle 11
        alu_operation_i = ALU_OP_DIV; a_i = 64'd1000; b_i = 64'd3; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) begin
            @(posedge clk_i); #1;
        end
        kill_i = 1'b1;
        @(negedge clk_i);
        chk("kill.stall_c10", {63'd0, stall_o}, 64'd1);
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        chk("kill.stall_c11", {63'd0, stall_o}, 64'd0);
        chk("kill.valid_c11", {63'd0, valid_o}, 64'd0);
        chk("kill.result_held", result_o, last_res);
        run_op("divu_after_kill", ALU_OP_DIVU, 64'd12345, 64'd10, 64'd1234, 66);

        // Reset at cycle 20 of a DIV
        alu_operation_i = ALU_OP_DIV; a_i = 64'd999; b_i = 64'd7; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (19) begin
            @(posedge clk_i); #1;
        end
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_mid.valid", {63'd0, valid_o}, 64'd0);
        chk("rst_mid.result", result_o, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_mid.stall", {63'd0, stall_o}, 64'd0);
        spurious = 0;
        repeat (70) begin
            @(negedge clk_i);
            if (valid_o) spurious++;
        end
        chk("rst_mid.no_valid", 64'(spurious), 64'd0);
        @(posedge clk_i); #1;

        // Randomized back-to-back ops against the reference model
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d", i), op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m_div_iter.md
Name: m_div_iter

Overview:
- Iterative radix-2 restoring divider for the RV64 M extension.
- Sits beside the M-extension ALU in the execute stage and replaces its single-cycle divide path.
- Accepts DIV/DIVU/REM/REMU/DIVW/DIVUW/DIVW/REMW/REMUW operands from the issue side, then holds the pipeline via stall_o until the result is ready.
- Returns the result on a one-cycle valid pulse, which the ALU result mux consumes.

Parameters:
- XLEN, 64, datapath width; must equal the global `XLEN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  request: operands and op are valid this cycle.
- kill_i  in  1  pipeline flush; abandons any in-flight division.
- alu_operation_i  in  6  `ALU_OP_* encoding from Lucid64.vh.
- a_i  in  XLEN  dividend (rs1).
- b_i  in  XLEN  divisor (rs2).
- result_o  out  XLEN  quotient or remainder, RISC-V formatted.
- valid_o  out  1  one-cycle pulse; result_o is valid.
- stall_o  out  1  hold upstream pipeline.

Behaviour:
- Reset (rst_ni low at a clock edge):
  - state goes to IDLE.
  - valid_o=0, result_o=0, iteration counter=0.
  - stall_o=0 once in IDLE.
  - Reset mid-division discards the operation; no valid_o is produced.
- Div op: alu_operation_i is one of the eight DIV*/REM* codes. Any other op with start_i is ignored: no state change, stall_o=0.
- States:
  - IDLE:
    - Accept when start_i and div op and not kill_i. Latch op, magnitudes |a| and |b| (signed ops only), result-sign flags and W flag.
    - For W ops, use bits [31:0]: sign-extend for DIVW/REMW, zero-extend for DIVUW/REMUW.
    - If divisor==0 or signed overflow → DONE directly.
    - Otherwise → DIVIDE with counter = 32 (W) or 64.
    - Signed overflow means a=most-negative and b=-1, at the width in use.
  - DIVIDE:
    - One quotient bit per cycle. Shift {rem,quot} left by one; trial subtract divisor; keep the result if non-negative and set the quotient LSB.
    - Decrement the counter; at 1 → FIXUP.
  - FIXUP:
    - Negate the quotient if the operand signs differ (signed ops). Negate the remainder if the dividend was negative.
    - Select quotient or remainder.
    - W ops: sign-extend bit 31 to XLEN. This applies to DIVUW/REMUW too.
    - → DONE.
  - DONE: valid_o=1 for exactly this cycle, result_o registered → IDLE.
- Special results:
  - Divide by zero: quotient = all ones (-1 at the op width, then sign-extended); remainder = dividend.
  - Overflow: quotient = most-negative value; remainder = 0.
- Latency, with start in cycle 0:
  - Normal 64-bit: valid_o in cycle 66.
  - W: valid_o in cycle 34.
  - Special case: valid_o in cycle 1.
- stall_o is combinational: (IDLE & start_i & div op & ~kill_i) | DIVIDE | FIXUP. It is low in DONE, so the consumer captures result_o and the pipeline advances in the same cycle.
- result_o holds its value after DONE until the next DONE or reset.
- start_i while not IDLE is ignored; upstream is stalled and must keep the request held.
- A new start is accepted in the cycle after DONE (back-to-back).
- kill_i in any state returns to IDLE next cycle, suppresses valid_o, and leaves result_o unchanged. kill_i wins over a simultaneous start_i.

Decomposition:
- Lucid64.vh (shared) holds `XLEN, the `ALU_OP_* codes, `NEGATIVE_1, `NEGATIVE_1_W, `DIV_MOST_NEG_INT and `DIV_MOST_NEG_INT_W. Add `DIV_STATE_* localparam encodings local to the module.
- No sub-module: the shift/subtract step and sign fixup are small enough to stay inline.
- The formal bench compares against the M-extension ALU's combinational divide results.

Test Plan:
- DIV a=-7, b=2 → stall_o high cycles 0–65; valid_o cycle 66; result 0xFFFF_FFFF_FFFF_FFFD (-3). REM same operands → 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU a=100, b=0 → valid_o cycle 1, result all ones. REMU same operands → 100.
- DIV a=0x8000_0000_0000_0000, b=-1 → valid_o cycle 1, result 0x8000_0000_0000_0000. REM same operands → 0.
- DIVUW a=0x0000_0000_FFFF_FFFE, b=1 → valid_o cycle 34, result 0xFFFF_FFFF_FFFF_FFFE. REMW a=0x1_0000_0007, b=-2 → 1.
- kill_i asserted at cycle 10 of a DIV → IDLE at cycle 11; no valid_o; stall_o low from cycle 11; a new DIVU started at cycle 11 completes correctly.
- rst_ni low at cycle 20 of a DIV → valid_o=0 and result_o=0 next cycle. Also check: start_i with ALU_OP_MUL leaves stall_o low and produces no valid_o.
